// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write arbiter.
// Contents: data/address widths, XZR index, conflict counter width,
// requester id enum, write-request struct and a "real request" helper.
package regfile_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 16;
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] regn;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    // A request that will actually change the register file.
    function automatic logic is_real(input wr_req_t r);
        return r.valid && (r.regn != ZERO_REG);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
// Ports:
//   clock, reset_n   clock and async active-low reset
//   req_a, req_b     real (non-XZR) requests
//   gnt_a, gnt_b     one-hot-or-zero grant, combinational
// The pointer names the side that wins the next conflict. After any grant it
// points at the side that did not win, so a lone grant to the pointer's
// opposite side leaves the pointer where it was.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    req_id_t ptr_q, ptr_d;

    always_comb begin
        gnt_a = req_a & (~req_b | (ptr_q == REQ_A));
        gnt_b = req_b & ~gnt_a;
        ptr_d = ptr_q;
        if (gnt_a)
            ptr_d = REQ_B;
        else if (gnt_b)
            ptr_d = REQ_A;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            ptr_q <= REQ_A;
        else
            ptr_q <= ptr_d;
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register file's single write port between requester A (ALU/EX)
// and requester B (load/memory).
// Ports:
//   clock, reset_n                 clock and async active-low reset
//   a_valid/a_ready/a_reg/a_data   requester A handshake and payload
//   b_valid/b_ready/b_reg/b_data   requester B handshake and payload
//   RegWrite/WriteReg/WriteData    registered write port to the register file
//   rd_addr1/rd_addr2              decode read addresses
//   pend_hit1/pend_hit2            read address matches an in-flight write
//   conflict_cnt                   saturating count of two-real-request cycles
module regfile_wr_arbiter
    import regfile_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              pend_hit1,
    output logic              pend_hit2,
    output logic [CNT_W-1:0]  conflict_cnt
);

    wr_req_t req_a, req_b;
    logic    real_a, real_b;
    logic    zero_a, zero_b;
    logic    gnt_a, gnt_b;

    logic              we_q;
    logic [ADDR_W-1:0] wreg_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  conflict_q;

    assign req_a = '{valid: a_valid, regn: a_reg, data: a_data};
    assign req_b = '{valid: b_valid, regn: b_reg, data: b_data};

    assign real_a = is_real(req_a);
    assign real_b = is_real(req_b);
    assign zero_a = req_a.valid & (req_a.regn == ZERO_REG);
    assign zero_b = req_b.valid & (req_b.regn == ZERO_REG);

    // XZR writes never reach the arbiter, so they cannot move its pointer.
    rr_arbiter2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req_a   (real_a),
        .req_b   (real_b),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b)
    );

    assign a_ready = reset_n & (gnt_a | zero_a);
    assign b_ready = reset_n & (gnt_b | zero_b);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else if (gnt_a) begin
            we_q    <= 1'b1;
            wreg_q  <= req_a.regn;
            wdata_q <= req_a.data;
        end else if (gnt_b) begin
            we_q    <= 1'b1;
            wreg_q  <= req_b.regn;
            wdata_q <= req_b.data;
        end else begin
            we_q    <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            conflict_q <= '0;
        else if (real_a && real_b && !(&conflict_q))
            conflict_q <= conflict_q + 1'b1;
    end

    // Hazard compare covers the write in the output flops and any write still
    // presented by a requester, granted or not.
    always_comb begin
        pend_hit1 = (rd_addr1 != ZERO_REG) &&
                    ((we_q && (wreg_q == rd_addr1)) ||
                     (a_valid && (a_reg == rd_addr1)) ||
                     (b_valid && (b_reg == rd_addr1)));
        pend_hit2 = (rd_addr2 != ZERO_REG) &&
                    ((we_q && (wreg_q == rd_addr2)) ||
                     (a_valid && (a_reg == rd_addr2)) ||
                     (b_valid && (b_reg == rd_addr2)));
    end

    assign RegWrite     = we_q;
    assign WriteReg     = wreg_q;
    assign WriteData    = wdata_q;
    assign conflict_cnt = conflict_q;

endmodule
